// File: rtl/rvfi_trace_buffer.sv
// Trace buffer: captures RVFI retirements into a FIFO that software reads out over a register bus.
// The bus answers one cycle after each request and never stalls; a retirement arriving while the FIFO is full is dropped and counted.
module rvfi_trace_buffer #(
  parameter int unsigned Depth        = 16,
  parameter int unsigned IrqThreshold = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rvfi_valid_i,
  input  logic [63:0] rvfi_order_i,
  input  logic [31:0] rvfi_insn_i,
  input  logic        rvfi_trap_i,
  input  logic [31:0] rvfi_pc_rdata_i,
  input  logic [4:0]  rvfi_rd_addr_i,
  input  logic [31:0] rvfi_rd_wdata_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        irq_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] wdata;
    logic [31:0] meta;
  } rec_t;

  rec_t          mem [Depth];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          enable, overflow, order_err, have_last;
  logic [63:0]   last_order;
  logic [31:0]   drop_cnt;

  rec_t        rec_in, head;
  logic        empty, full;
  logic [2:0]  reg_idx;
  logic        bus_err, ctrl_wr, pop_wr, clear;
  logic        push_req, do_push, do_pop, drop, order_bad;
  logic [31:0] rd_val, status_word;
  logic [8:0]  count9;
  logic        unused_bits;

  assign unused_bits = ^{addr_i[31:5], addr_i[1:0], wdata_i[31:2]};

  always_comb begin
    rec_in       = '0;
    rec_in.pc    = rvfi_pc_rdata_i;
    rec_in.insn  = rvfi_insn_i;
    rec_in.wdata = rvfi_rd_wdata_i;
    rec_in.meta  = {rvfi_order_i[15:0], 10'b0, rvfi_trap_i, rvfi_rd_addr_i};
  end

  assign empty       = (count == '0);
  assign full        = (count == CW'(Depth));
  assign head        = empty ? '0 : mem[rptr];
  assign count9      = 9'(count);
  assign status_word = {12'b0, order_err, overflow, full, empty, 7'b0, count9};
  assign reg_idx     = addr_i[4:2];

  // Register decode; byte enables must cover the whole word for any access.
  always_comb begin
    bus_err = 1'b0;
    ctrl_wr = 1'b0;
    pop_wr  = 1'b0;
    rd_val  = '0;
    if (req_i) begin
      if (be_i != 4'hF) begin
        bus_err = 1'b1;
      end else if (we_i) begin
        case (reg_idx)
          3'd1:    ctrl_wr = 1'b1;
          3'd6:    pop_wr  = 1'b1;
          default: bus_err = 1'b1;
        endcase
      end else begin
        case (reg_idx)
          3'd0:    rd_val  = status_word;
          3'd1:    rd_val  = {31'b0, enable};
          3'd2:    rd_val  = head.pc;
          3'd3:    rd_val  = head.insn;
          3'd4:    rd_val  = head.wdata;
          3'd5:    rd_val  = head.meta;
          3'd6:    bus_err = 1'b1;
          default: rd_val  = drop_cnt;
        endcase
      end
    end
  end

  // Pop is evaluated first so a full FIFO can accept a push in the same cycle.
  assign clear     = ctrl_wr & wdata_i[1];
  assign push_req  = enable & rvfi_valid_i;
  assign do_pop    = pop_wr & ~empty & ~clear;
  assign do_push   = push_req & (~full | do_pop) & ~clear;
  assign drop      = push_req & full & ~do_pop & ~clear;
  assign order_bad = have_last & (rvfi_order_i != last_order + 64'd1);

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= rec_in;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      enable     <= 1'b0;
      overflow   <= 1'b0;
      order_err  <= 1'b0;
      have_last  <= 1'b0;
      last_order <= '0;
      drop_cnt   <= '0;
      rvalid_o   <= 1'b0;
      err_o      <= 1'b0;
      rdata_o    <= '0;
      irq_o      <= 1'b0;
    end else begin
      if (clear) begin
        wptr       <= '0;
        rptr       <= '0;
        count      <= '0;
        overflow   <= 1'b0;
        order_err  <= 1'b0;
        have_last  <= 1'b0;
        last_order <= '0;
        drop_cnt   <= '0;
      end else begin
        if (do_push) wptr <= wptr + AW'(1);
        if (do_pop)  rptr <= rptr + AW'(1);
        count <= count + CW'(do_push) - CW'(do_pop);
        if (drop) begin
          overflow <= 1'b1;
          if (drop_cnt != 32'hFFFF_FFFF) drop_cnt <= drop_cnt + 32'd1;
        end
        if (do_push) begin
          last_order <= rvfi_order_i;
          have_last  <= 1'b1;
          if (order_bad) order_err <= 1'b1;
        end
      end
      if (ctrl_wr) enable <= wdata_i[0];
      rvalid_o <= req_i;
      err_o    <= bus_err;
      rdata_o  <= bus_err ? 32'b0 : rd_val;
      irq_o    <= enable & ((32'(count) >= IrqThreshold) | overflow);
    end
  end

endmodule

// File: doc/rvfi_trace_buffer.md
RVFI_TRACE_BUFFER -- requirements
Module: rvfi_trace_buffer

Interface
REQ-001 SHALL have parameter Depth, default 16, meaning FIFO entries (power of 2, 4..256).
REQ-002 SHALL have parameter IrqThreshold, default 8, meaning occupancy at or above which irq_o asserts.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state on rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port rvfi_valid_i, input, 1 bit: retirement strobe, one instruction per cycle.
REQ-006 SHALL have port rvfi_order_i, input, 64 bits: retirement order.
REQ-007 SHALL have port rvfi_insn_i, input, 32 bits: instruction word.
REQ-008 SHALL have port rvfi_trap_i, input, 1 bit: trap flag.
REQ-009 SHALL have port rvfi_pc_rdata_i, input, 32 bits: retired PC.
REQ-010 SHALL have port rvfi_rd_addr_i, input, 5 bits: destination register.
REQ-011 SHALL have port rvfi_rd_wdata_i, input, 32 bits: destination write data.
REQ-012 SHALL have bus device ports req_i (1), we_i (1), be_i (4), addr_i (32), wdata_i (32), all inputs.
REQ-013 SHALL have bus device ports rvalid_o (1), rdata_o (32), err_o (1), all outputs.
REQ-014 SHALL have port irq_o, output, 1 bit: level interrupt.

Function
REQ-015 SHALL push record {pc, insn, rd_wdata, meta} on rvfi_valid_i when CTRL.enable=1; meta = {order[15:0], 10'b0, trap, rd_addr}.
REQ-016 SHALL decode addr_i[4:2]; addr_i[31:5] ignored (interconnect masks base).
REQ-017 SHALL map 0x00 STATUS (RO): [8:0] count, [16] empty, [17] full, [18] overflow, [19] order_err.
REQ-018 SHALL map 0x04 CTRL (RW): [0] enable, reset 0; writing [1]=1 clears FIFO, overflow, order_err, drop_cnt; [1] reads 0.
REQ-019 SHALL map 0x08 HEAD_PC, 0x0C HEAD_INSN, 0x10 HEAD_WDATA, 0x14 HEAD_META (RO): head entry fields, 0 when empty.
REQ-020 SHALL map 0x18 POP (WO, reads 0): any write pops the head entry; pop on empty is ignored.
REQ-021 SHALL map 0x1C DROP_CNT (RO): 32-bit count of dropped pushes, saturating at 0xFFFFFFFF.
REQ-022 SHALL assert rvalid_o exactly one cycle after every accepted req_i, reads and writes; one request per cycle, no back-pressure.
REQ-023 SHALL return rdata_o for the sampled cycle's state; rdata_o = 0 on writes.
REQ-024 SHALL assert err_o with rvalid_o for writes to RO registers (no state change), for reads of POP, and for be_i != 4'hF; rdata_o = 0 then.
REQ-025 SHALL, on push while full and no same-cycle pop, drop the record, set overflow sticky, and increment DROP_CNT.
REQ-026 SHALL, on simultaneous push and pop while full, accept both; count unchanged, no overflow.
REQ-027 SHALL, on simultaneous push and pop while empty, accept the push and ignore the pop; count = 1.
REQ-028 SHALL let clear win over a same-cycle push and pop; count = 0 next cycle.
REQ-029 SHALL set order_err sticky when an accepted push has rvfi_order_i != last_order+1; the first push after reset or clear is exempt.
REQ-030 SHALL wrap read/write pointers modulo Depth; count is Depth+1 wide-safe (0..Depth).
REQ-031 SHALL drive irq_o = enable & (count >= IrqThreshold | overflow), registered, one cycle after the triggering state.
REQ-032 SHALL ignore rvfi_valid_i when enable=0; no drop counted, no order check.

Reset
REQ-033 SHALL, on rst_i asserted (asynchronous, any cycle, incl. mid-transaction), clear pointers, count, enable, overflow, order_err, DROP_CNT, last_order, rvalid_o, err_o, rdata_o, irq_o to 0.
REQ-034 SHALL not return rvalid_o for a request in flight when reset hits; FIFO storage need not be reset.

Verification
REQ-035 SHALL cover: enable, 3 retirements (order 1,2,3, pc 0x100080/84/88) -> STATUS count=3; HEAD_PC=0x100080; POP then HEAD_PC=0x100084.
REQ-036 SHALL cover: 17 retirements at Depth=16, no pops -> count=16, full=1, overflow=1, DROP_CNT=1, irq_o=1.
REQ-037 SHALL cover: full FIFO, push and POP in the same cycle -> count stays 16, overflow=0, new record at the tail.
REQ-038 SHALL cover: orders 5,6,8 -> order_err=1 after the third push; CTRL clear -> STATUS=0x00010000.
REQ-039 SHALL cover: write to STATUS, write with be_i=4'h3, read of POP -> err_o=1 with rvalid_o each time, no state change.
REQ-040 SHALL cover: rst_i pulse mid-read with count=5 -> rvalid_o=0 next cycle, STATUS=0x00010000, enable=0.
